// File: rtl/blur_pixel_feeder.sv
`default_nettype none
// ============================================================================
// blur_pixel_feeder : row-by-row frame reader feeding the horizontal blur filter
// Rev 1.0
// ============================================================================
module blur_pixel_feeder #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int ADDR_W     = 20,
  parameter int PRIME_CNT  = 7
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              wb_en,
  output logic [2:0]        mode_wb,
  output logic [31:0]       data,
  output logic              cap_en,
  output logic [15:0]       pix_x,
  output logic [15:0]       pix_y,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_PRIME = 3'd3,
    S_EMIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam int              PC_W    = (PRIME_CNT > 1) ? $clog2(PRIME_CNT) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'((PRIME_CNT > 0) ? (PRIME_CNT - 1) : 0);
  localparam logic [15:0]     X_LAST  = 16'(IMG_WIDTH - 1);
  localparam logic [15:0]     Y_LAST  = 16'(IMG_HEIGHT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       x_q, x_d;
  logic [15:0]       y_q, y_d;
  logic [31:0]       data_q, data_d;
  logic [PC_W-1:0]   prime_q, prime_d;
  logic              pend_q, pend_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      data_q  <= '0;
      prime_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      data_q  <= data_d;
      prime_q <= prime_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    x_d     = x_q;
    y_d     = y_q;
    data_d  = data_q;
    prime_d = prime_q;
    pend_d  = pend_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_REQ;
          addr_d  = base_addr;
          x_d     = '0;
          y_d     = '0;
        end
      end
      S_REQ: begin
        pend_d  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid && pend_q) begin
          data_d  = mem_rdata;
          pend_d  = 1'b0;
          prime_d = '0;
          state_d = ((x_q == 16'd0) && (PRIME_CNT > 0)) ? S_PRIME : S_EMIT;
        end
      end
      S_PRIME: begin
        if (prime_q == PC_LAST) begin
          state_d = S_EMIT;
        end else begin
          prime_d = prime_q + PC_W'(1);
        end
      end
      S_EMIT: begin
        if ((x_q == X_LAST) && (y_q == Y_LAST)) begin
          state_d = S_DONE;
        end else begin
          // Running address counter: rows are contiguous, so no y*W product needed.
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_REQ;
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + 16'd1;
          end else begin
            x_d = x_q + 16'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides start and drops any in-flight read so a late response is ignored.
    if (abort) begin
      state_d = S_IDLE;
      addr_d  = '0;
      x_d     = '0;
      y_d     = '0;
      data_d  = '0;
      prime_d = '0;
      pend_d  = 1'b0;
    end
  end

  assign mem_rd_en = (state_q == S_REQ);
  assign mem_addr  = (state_q == S_REQ) ? addr_q : '0;
  assign wb_en     = (state_q == S_PRIME) || (state_q == S_EMIT);
  assign cap_en    = (state_q == S_EMIT);
  assign pix_x     = (state_q == S_EMIT) ? x_q : 16'd0;
  assign pix_y     = (state_q == S_EMIT) ? y_q : 16'd0;
  assign busy      = (state_q != S_IDLE);
  assign mode_wb   = (state_q != S_IDLE) ? 3'b101 : 3'b000;
  assign done      = (state_q == S_DONE);
  assign data      = data_q;

endmodule
`default_nettype wire

// File: tb/tb_blur_pixel_feeder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_blur_pixel_feeder : directed self-checking bench with a frame-level model
// Rev 1.0
// ============================================================================
module tb_blur_pixel_feeder;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 20;
  localparam int PC = 7;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata = '0;
  logic          mem_rvalid = 1'b0;
  logic          wb_en;
  logic [2:0]    mode_wb;
  logic [31:0]   data;
  logic          cap_en;
  logic [15:0]   pix_x;
  logic [15:0]   pix_y;
  logic          busy;
  logic          done;

  blur_pixel_feeder #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .ADDR_W    (AW),
    .PRIME_CNT (PC)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_rvalid(mem_rvalid),
    .wb_en     (wb_en),
    .mode_wb   (mode_wb),
    .data      (data),
    .cap_en    (cap_en),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        cap;
    int          x;
    int          y;
  } wb_t;

  wb_t           wb_q[$];
  logic [AW-1:0] addr_q[$];
  logic [AW-1:0] seen_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat = 1;
  int rcnt = 0;
  logic [AW-1:0] raddr = '0;
  int wb_cnt = 0;
  int done_cnt = 0;
  int cnt_104 = 0;
  int cap_104 = 0;
  int cap104_x = -1;
  int cap104_y = -1;
  int last_cap_cyc = 0;
  bit prev_last = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memval(input logic [AW-1:0] a);
    return {12'hA50, a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected frame: every pixel read once in raster order; row-first pixels repeat PC extra times.
  task automatic model_frame(input logic [AW-1:0] b);
    logic [AW-1:0] a;
    wb_t e;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        a = b + AW'(y * W + x);
        addr_q.push_back(a);
        e.d = memval(a);
        e.x = x;
        e.y = y;
        if (x == 0) begin
          for (int k = 0; k < PC; k++) begin
            e.cap = 1'b0;
            wb_q.push_back(e);
          end
        end
        e.cap = 1'b1;
        wb_q.push_back(e);
      end
    end
  endtask

  // Memory responder: answers each read after 'lat' cycles, never cancels in-flight responses.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = memval(raddr);
        end
      end
      if (mem_rd_en === 1'b1) begin
        chk("rd_while_outstanding", 32'(rcnt != 0), 32'd0);
        raddr = mem_addr;
        seen_q.push_back(mem_addr);
        rcnt = lat;
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    wb_t e;
    logic [AW-1:0] ea;
    forever begin
      @(negedge clk);
      chk("mode_wb_vs_busy", 32'(mode_wb), busy ? 32'd5 : 32'd0);
      if (cap_en && !wb_en) chk("cap_without_wb", 32'd1, 32'd0);
      if (mem_rd_en) begin
        if (addr_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
        else begin
          ea = addr_q.pop_front();
          chk("rd_addr", 32'(mem_addr), 32'(ea));
        end
      end
      if (wb_en) begin
        wb_cnt++;
        if (data == 32'hA500_0104) begin
          cnt_104++;
          if (cap_en) begin
            cap_104++;
            cap104_x = int'(pix_x);
            cap104_y = int'(pix_y);
          end
        end
        if (wb_q.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
        else begin
          e = wb_q.pop_front();
          chk("wb_data", data, e.d);
          chk("wb_cap", 32'(cap_en), 32'(e.cap));
          if (e.cap) begin
            chk("pix_x", 32'(pix_x), 32'(e.x));
            chk("pix_y", 32'(pix_y), 32'(e.y));
          end
        end
        if (cap_en) begin
          if (pix_x != 16'd0) chk("wb_gap", 32'(cyc - last_cap_cyc), 32'(lat + 2));
          last_cap_cyc = cyc;
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_after_last_emit", 32'(prev_last), 32'd1);
        chk("done_model_drained", 32'(wb_q.size() + addr_q.size()), 32'd0);
      end
      prev_last = wb_en && cap_en && (pix_x == 16'(W - 1)) && (pix_y == 16'(H - 1));
    end
  end

  task automatic do_start(input logic [AW-1:0] b, input bit accept);
    @(posedge clk);
    #1;
    base_addr = b;
    start = 1'b1;
    if (accept) model_frame(b);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_frame(input int d0, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (!busy && done_cnt > d0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  initial begin
    int d0;
    int w0;
    bit ok;

    // Reset state
    #2;
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_mode_wb", 32'(mode_wb), 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;

    // Basic frame, latency 1
    lat = 1;
    seen_q.delete();
    d0 = done_cnt; w0 = wb_cnt;
    do_start(20'h00100, 1'b1);
    wait_frame(d0, "t1_frame_timeout");
    chk("t1_nreads", 32'(seen_q.size()), 32'd8);
    chk("t1_addr_first", 32'(seen_q[0]), 32'h100);
    chk("t1_addr_last", 32'(seen_q[7]), 32'h107);
    chk("t1_wb_count", 32'(wb_cnt - w0), 32'd22);
    chk("t1_row1_hold", 32'(cnt_104), 32'd8);
    chk("t1_row1_cap", 32'(cap_104), 32'd1);
    chk("t1_row1_px", 32'(cap104_x), 32'd0);
    chk("t1_row1_py", 32'(cap104_y), 32'd1);
    chk("t1_done_once", 32'(done_cnt - d0), 32'd1);

    // Longer latencies
    lat = 3;
    d0 = done_cnt; w0 = wb_cnt;
    do_start(20'h00200, 1'b1);
    wait_frame(d0, "t2a_frame_timeout");
    chk("t2a_wb_count", 32'(wb_cnt - w0), 32'd22);
    lat = 5;
    d0 = done_cnt; w0 = wb_cnt;
    do_start(20'h00200, 1'b1);
    wait_frame(d0, "t2b_frame_timeout");
    chk("t2b_wb_count", 32'(wb_cnt - w0), 32'd22);

    // Abort while waiting on pixel (2,0); the late response must be ignored
    lat = 3;
    do_start(20'h00300, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (mem_rd_en && mem_addr == 20'h00302) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t3_reach_px2", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    abort = 1'b1;
    wb_q.delete();
    addr_q.delete();
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    chk("t3_busy_after_abort", 32'(busy), 32'd0);
    chk("t3_data_after_abort", data, 32'd0);
    w0 = wb_cnt;
    repeat (6) @(negedge clk);
    chk("t3_no_late_wb", 32'(wb_cnt - w0), 32'd0);
    seen_q.delete();
    d0 = done_cnt;
    do_start(20'h00300, 1'b1);
    wait_frame(d0, "t3_restart_timeout");
    chk("t3_restart_base", 32'(seen_q[0]), 32'h300);

    // Start mid-frame is ignored
    lat = 2;
    d0 = done_cnt; w0 = wb_cnt;
    do_start(20'h00040, 1'b1);
    repeat (15) @(posedge clk);
    do_start(20'h00999, 1'b0);
    wait_frame(d0, "t4_frame_timeout");
    repeat (4) @(negedge clk);
    chk("t4_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t4_wb_count", 32'(wb_cnt - w0), 32'd22);

    // Address wrap at the top of the address space
    lat = 1;
    seen_q.delete();
    d0 = done_cnt;
    do_start(20'hFFFFE, 1'b1);
    wait_frame(d0, "t5_frame_timeout");
    chk("t5_addr0", 32'(seen_q[0]), 32'hFFFFE);
    chk("t5_addr1", 32'(seen_q[1]), 32'hFFFFF);
    chk("t5_addr2", 32'(seen_q[2]), 32'h00000);
    chk("t5_addr3", 32'(seen_q[3]), 32'h00001);

    // Asynchronous reset in the middle of priming
    d0 = done_cnt;
    do_start(20'h00010, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wb_en && !cap_en) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t6_reach_prime", 32'(ok), 32'd1);
    #2;
    n_rst = 1'b0;
    wb_q.delete();
    addr_q.delete();
    #1;
    chk("t6_wb_en", 32'(wb_en), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_mode_wb", 32'(mode_wb), 32'd0);
    chk("t6_data", data, 32'd0);
    chk("t6_rd_en", 32'(mem_rd_en), 32'd0);
    rcnt = 0;
    mem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_no_done", 32'(done_cnt - d0), 32'd0);

    // start and abort together: abort wins
    @(posedge clk);
    #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("t7_abort_wins", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("t7_no_reads", 32'(addr_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
